param_sp_ram: RTL

- Parametrised synchronous single-port RAM; next generation of the team's 8x16 RAM block.
- Adds the following over that block:
  - separate din/dout instead of a bidirectional bus
  - per-byte write enables
  - configurable read latency with a valid strobe
  - selectable read-during-write mode
  - a hardware clear engine that zero-fills memory after reset or on request
- Used as local scratch/buffer storage by datapath blocks.

---
 rtl/param_sp_ram.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/param_sp_ram.sv
// Synchronous single-port RAM with byte-lane writes, 1- or 2-cycle read latency,
// selectable read-during-write behaviour and a clear engine that fills memory with CLEAR_VAL.
module param_sp_ram #(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       ADDR_W    = 4,
    parameter int unsigned       DEPTH     = 16,
    parameter int unsigned       RD_LAT    = 1,
    parameter int unsigned       RDW_MODE  = 0,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     din,
    input  logic                  clr,
    output logic [DATA_W-1:0]     dout,
    output logic                  dout_valid,
    output logic                  busy
);

    localparam int unsigned       NB       = DATA_W / 8;
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [0:0]        S_IDLE   = 1'b0;
    localparam logic [0:0]        S_CLEAR  = 1'b1;

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $fatal(1, "param_sp_ram: RD_LAT must be 1 or 2");
    end
    if (RDW_MODE > 2) begin : g_bad_rdw
        $fatal(1, "param_sp_ram: RDW_MODE must be 0, 1 or 2");
    end
    if (DATA_W == 0 || (DATA_W % 8) != 0) begin : g_bad_dw
        $fatal(1, "param_sp_ram: DATA_W must be a non-zero multiple of 8");
    end
    if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
        $fatal(1, "param_sp_ram: DEPTH must be in 1..2**ADDR_W");
    end

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_acc;
    logic              w_in_range;
    logic              w_wr;
    logic              w_rd;
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_rd_data;

    logic              r_s1_vld;
    logic [DATA_W-1:0] r_s1_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // clr is only honoured from IDLE; a sweep in progress always runs to the end
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: if (r_ptr == PTR_LAST) w_state_nxt = S_IDLE;
            default: if (clr)               w_state_nxt = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (r_state == S_CLEAR) begin
            if (r_ptr != PTR_LAST) r_ptr <= r_ptr + ADDR_W'(1);
        end else if (clr) begin
            r_ptr <= '0;
        end
    end

    assign busy       = (r_state == S_CLEAR);
    assign w_acc      = (r_state == S_IDLE) && en && !clr;
    assign w_in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
    assign w_wr       = w_acc && we && w_in_range;
    assign w_rd       = w_acc && (!we || RDW_MODE != 0);
    assign w_old      = w_in_range ? r_mem[addr] : '0;

    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < int'(NB); i++) begin
            if (be[i]) w_merged[8*i +: 8] = din[8*i +: 8];
        end
    end

    // Write-first returns the merged word; out-of-range accesses read as zero
    always_comb begin
        w_rd_data = w_old;
        if (!w_in_range)                w_rd_data = '0;
        else if (we && RDW_MODE == 2)   w_rd_data = w_merged;
    end

    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_ptr] <= CLEAR_VAL;
        end else if (w_wr) begin
            r_mem[addr] <= w_merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_data <= '0;
        end else begin
            r_s1_vld <= w_rd;
            if (w_rd) r_s1_data <= w_rd_data;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic              r_s2_vld;
        logic [DATA_W-1:0] r_s2_data;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s2_vld  <= 1'b0;
                r_s2_data <= '0;
            end else begin
                r_s2_vld <= r_s1_vld;
                if (r_s1_vld) r_s2_data <= r_s1_data;
            end
        end

        assign dout       = r_s2_data;
        assign dout_valid = r_s2_vld;
    end else begin : g_lat1
        assign dout       = r_s1_data;
        assign dout_valid = r_s1_vld;
    end

endmodule
